// File: rtl/calc_pkg.sv
// Shared opcode encodings and sequencer state type for the signed calculator.
package calc_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_CMP = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_MUL  = 2'b10,
      ST_DONE = 2'b11
   } state_e;

endpackage

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: loads on start, one step per clock,
// the full 2*WIDTH product is presented combinationally alongside valid on the last step.
module booth_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] product,
   output logic               valid
);

   localparam int CW = $clog2(WIDTH + 1);

   // One guard bit on the accumulator so negating the most negative multiplicand cannot wrap
   logic signed [WIDTH:0] acc;
   logic signed [WIDTH:0] mcand;
   logic signed [WIDTH:0] sum;
   logic [WIDTH-1:0]      mq;
   logic                  q1;
   logic                  running;
   logic [CW-1:0]         cnt;

   always_comb begin
      sum = acc;
      case ({mq[0], q1})
         2'b01:   sum = acc + mcand;
         2'b10:   sum = acc - mcand;
         default: sum = acc;
      endcase
   end

   // The final step's shifted result is the product, so it is usable on the same edge that retires it
   assign product = {sum, mq[WIDTH-1:1]};
   assign valid   = running && (cnt == CW'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         mcand   <= '0;
         mq      <= '0;
         q1      <= 1'b0;
         cnt     <= '0;
         running <= 1'b0;
      end else if (start) begin
         acc     <= '0;
         mcand   <= {a[WIDTH-1], a};
         mq      <= b;
         q1      <= 1'b0;
         cnt     <= CW'(WIDTH);
         running <= 1'b1;
      end else if (running) begin
         acc <= {sum[WIDTH], sum[WIDTH:1]};
         mq  <= {sum[0], mq[WIDTH-1:1]};
         q1  <= mq[0];
         cnt <= cnt - 1'b1;
         if (cnt == CW'(1)) begin
            running <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/calc_op_sequencer.sv
// Operation sequencer for the signed calculator: captures a request, computes one
// result lane and drives the registered select for the downstream 4:1 lane muxes.
module calc_op_sequencer
   import calc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [1:0]         sel,
   output logic [2*WIDTH-1:0] r0,
   output logic [2*WIDTH-1:0] r1,
   output logic [2*WIDTH-1:0] r2,
   output logic [2*WIDTH-1:0] r3,
   output logic               ovf
);

   localparam int RW = 2 * WIDTH;

   state_e state;
   state_e state_nxt;

   logic signed [WIDTH-1:0] a_q;
   logic signed [WIDTH-1:0] b_q;
   logic signed [RW-1:0]    a_ext;
   logic signed [RW-1:0]    b_ext;
   logic [RW-1:0]           sum_val;
   logic [RW-1:0]           diff_val;
   logic [RW-1:0]           cmp_val;
   logic [RW-1:0]           mul_product;
   logic                    mul_valid;
   logic                    accept;

   // A lane value fits in WIDTH signed bits only if its upper WIDTH+1 bits are all equal
   function automatic logic out_of_range(input logic [RW-1:0] v);
      return !((&v[RW-1:WIDTH-1]) || !(|v[RW-1:WIDTH-1]));
   endfunction

   assign ready  = (state == ST_IDLE) || (state == ST_DONE);
   assign busy   = (state == ST_EXEC) || (state == ST_MUL);
   assign done   = (state == ST_DONE);
   assign accept = start && ready;

   assign a_ext    = {{WIDTH{a_q[WIDTH-1]}}, a_q};
   assign b_ext    = {{WIDTH{b_q[WIDTH-1]}}, b_q};
   assign sum_val  = a_ext + b_ext;
   assign diff_val = a_ext - b_ext;

   always_comb begin
      cmp_val = '0;
      if (a_q < b_q) begin
         cmp_val = '1;
      end else if (a_q > b_q) begin
         cmp_val = RW'(1);
      end
   end

   // Multiplier takes operands straight from the ports so its first step lands on the edge after accept
   booth_mul_seq #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (accept && (op == OP_MUL)),
      .a       (a),
      .b       (b),
      .product (mul_product),
      .valid   (mul_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nxt = (op == OP_MUL) ? ST_MUL : ST_EXEC;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_EXEC: state_nxt = ST_DONE;
         ST_MUL: begin
            if (mul_valid) begin
               state_nxt = ST_DONE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Only the lane chosen at accept is written; the rest hold for the downstream muxes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
         sel <= OP_ADD;
         r0  <= '0;
         r1  <= '0;
         r2  <= '0;
         r3  <= '0;
         ovf <= 1'b0;
      end else begin
         if (accept) begin
            a_q <= a;
            b_q <= b;
            sel <= op;
            ovf <= 1'b0;
         end
         if (state == ST_EXEC) begin
            case (sel)
               OP_ADD: begin
                  r0  <= sum_val;
                  ovf <= out_of_range(sum_val);
               end
               OP_SUB: begin
                  r1  <= diff_val;
                  ovf <= out_of_range(diff_val);
               end
               OP_CMP: begin
                  r3  <= cmp_val;
                  ovf <= 1'b0;
               end
               default: ;
            endcase
         end
         if ((state == ST_MUL) && mul_valid) begin
            r2  <= mul_product;
            ovf <= out_of_range(mul_product);
         end
      end
   end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer at WIDTH=8 with hand-computed expected lane values.
module tb_calc_op_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        ready;
   logic        busy;
   logic        done;
   logic [1:0]  sel;
   logic [15:0] r0;
   logic [15:0] r1;
   logic [15:0] r2;
   logic [15:0] r3;
   logic        ovf;

   int compared   = 0;
   int mismatched = 0;
   int lat;
   logic done_seen;

   calc_op_sequencer #(
      .WIDTH (8)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sel   (sel),
      .r0    (r0),
      .r1    (r1),
      .r2    (r2),
      .r3    (r3),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Issues one request, then returns 1 time unit after the edge where done first appears
   task automatic applyStimulus(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                                output int latency);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start   = 1'b0;
      latency = 0;
      while (!done && latency < 40) begin
         @(posedge clk);
         #1;
         latency++;
      end
      if (latency >= 40) begin
         checkOutput("done_timeout", 32'(latency), 32'd0);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = 8'h00;
      b     = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst_ready", 32'(ready), 32'd1);
      checkOutput("rst_busy",  32'(busy),  32'd0);
      checkOutput("rst_done",  32'(done),  32'd0);
      checkOutput("rst_sel",   32'(sel),   32'd0);
      checkOutput("rst_lanes", 32'(r0 | r1 | r2 | r3), 32'd0);
      checkOutput("rst_ovf",   32'(ovf),   32'd0);

      applyStimulus(2'b00, 8'd100, 8'd50, lat);
      checkOutput("add_lat",   32'(lat), 32'd1);
      checkOutput("add_r0",    32'(r0),  32'h0096);
      checkOutput("add_sel",   32'(sel), 32'd0);
      checkOutput("add_ovf",   32'(ovf), 32'd1);
      checkOutput("add_ready", 32'(ready), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("add_done_pulse", 32'(done), 32'd0);
      checkOutput("add_idle_ready", 32'(ready), 32'd1);

      applyStimulus(2'b01, 8'h80, 8'h01, lat);
      checkOutput("sub_r1",   32'(r1),  32'hFF7F);
      checkOutput("sub_sel",  32'(sel), 32'd1);
      checkOutput("sub_ovf",  32'(ovf), 32'd1);
      checkOutput("sub_r0",   32'(r0),  32'h0096);
      checkOutput("sub_r2r3", 32'({r2, r3}), 32'd0);

      applyStimulus(2'b10, 8'd7, 8'hFD, lat);
      checkOutput("mul_lat", 32'(lat), 32'd8);
      checkOutput("mul_r2",  32'(r2),  32'hFFEB);
      checkOutput("mul_ovf", 32'(ovf), 32'd0);
      checkOutput("mul_sel", 32'(sel), 32'd2);
      checkOutput("mul_r1",  32'(r1),  32'hFF7F);

      applyStimulus(2'b10, 8'h80, 8'h80, lat);
      checkOutput("mul_minmin_r2",  32'(r2),  32'h4000);
      checkOutput("mul_minmin_ovf", 32'(ovf), 32'd1);

      applyStimulus(2'b10, 8'h80, 8'h01, lat);
      checkOutput("mul_min1_r2",  32'(r2),  32'hFF80);
      checkOutput("mul_min1_ovf", 32'(ovf), 32'd0);

      applyStimulus(2'b10, 8'd127, 8'h80, lat);
      checkOutput("mul_maxmin_r2",  32'(r2),  32'hC080);
      checkOutput("mul_maxmin_ovf", 32'(ovf), 32'd1);

      applyStimulus(2'b11, 8'd5, 8'hFD, lat);
      checkOutput("cmp_gt_r3",  32'(r3),  32'h0001);
      checkOutput("cmp_gt_ovf", 32'(ovf), 32'd0);
      checkOutput("cmp_gt_lat", 32'(lat), 32'd1);
      applyStimulus(2'b11, 8'hFC, 8'hFC, lat);
      checkOutput("cmp_eq_r3", 32'(r3), 32'h0000);
      applyStimulus(2'b11, 8'hFC, 8'd2, lat);
      checkOutput("cmp_lt_r3", 32'(r3), 32'hFFFF);
      checkOutput("cmp_lt_sel", 32'(sel), 32'd3);
      checkOutput("cmp_lt_r2", 32'(r2), 32'hC080);

      // Start pulsed during a multiply must be ignored
      @(negedge clk);
      start = 1'b1;
      op    = 2'b10;
      a     = 8'd3;
      b     = 8'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      op    = 2'b00;
      a     = 8'd1;
      b     = 8'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("ign_busy", 32'(busy), 32'd1);
      lat = 3;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput("ign_lat", 32'(lat), 32'd8);
      checkOutput("ign_r2",  32'(r2),  32'h000F);
      checkOutput("ign_sel", 32'(sel), 32'd2);
      checkOutput("ign_r0",  32'(r0),  32'h0096);
      @(posedge clk);

      // Reset in the middle of a multiply aborts it without writing r2
      @(negedge clk);
      start = 1'b1;
      op    = 2'b10;
      a     = 8'd9;
      b     = 8'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("abort_lanes", 32'(r0 | r1 | r2 | r3), 32'd0);
      checkOutput("abort_flags", 32'({done, busy, ovf, sel}), 32'd0);
      checkOutput("abort_ready", 32'(ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         done_seen = done_seen | done;
      end
      checkOutput("abort_no_done", 32'(done_seen), 32'd0);
      checkOutput("abort_r2",      32'(r2),        32'd0);

      // Start held through DONE chains the next request with no idle cycle
      @(negedge clk);
      start = 1'b1;
      op    = 2'b00;
      a     = 8'd1;
      b     = 8'd2;
      @(posedge clk);
      #1;
      op = 2'b01;
      a  = 8'd10;
      b  = 8'd3;
      @(posedge clk);
      #1;
      checkOutput("b2b_done1", 32'(done), 32'd1);
      checkOutput("b2b_r0",    32'(r0),   32'h0003);
      @(posedge clk);
      #1;
      checkOutput("b2b_done1_end", 32'(done), 32'd0);
      checkOutput("b2b_busy",      32'(busy), 32'd1);
      checkOutput("b2b_sel",       32'(sel),  32'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("b2b_done2", 32'(done), 32'd1);
      checkOutput("b2b_r1",    32'(r1),   32'h0007);
      @(posedge clk);
      #1;
      checkOutput("b2b_done2_end", 32'(done),  32'd0);
      checkOutput("b2b_ready",     32'(ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
